rsa_modexp_ctrl: RTL

//  Sequencer for RSA modular exponentiation: result = msg^exp mod mod, via right-to-left

---
 rtl/rsa_modexp_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modexp_ctrl
//  Purpose  : Sequencer for RSA modular exponentiation, result = msg^exp mod mod,
//             using right-to-left square-and-multiply on one shared external
//             modular multiplier (P = A*B mod N). Owns the accumulator, base
//             and exponent shift registers and keeps at most one multiply
//             outstanding.
//  Ports    : clk, reset (async, active-low)
//             start, msg_i, exp_i, mod_i   - operand load / request
//             busy, ready, result_o        - status and result
//             mm_start, mm_a, mm_b, mm_n   - multiplier launch and operands
//             mm_done, mm_p                - multiplier completion and product
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] msg_i,
  input  logic [WIDTH-1:0] exp_i,
  input  logic [WIDTH-1:0] mod_i,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_o,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_p
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_MUL      = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_SQR      = 3'd4,
    S_SQR_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;

  logic w_load;      // accept a new operation
  logic w_acc_we;    // capture product into accumulator
  logic w_base_we;   // capture square into base
  logic w_shift;     // consume the current exponent bit
  logic w_last_bit;  // only bit 0 of the exponent is left

  // When the current bit is the most significant one, the square that would
  // prepare the next base is useless, so it is skipped.
  assign w_last_bit = (r_e[WIDTH-1:1] == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    mm_start    = 1'b0;
    busy        = 1'b0;
    ready       = 1'b0;
    w_load      = 1'b0;
    w_acc_we    = 1'b0;
    w_base_we   = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (r_e == '0) begin
          w_state_nxt = S_DONE;
        end else if (r_e[0]) begin
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_SQR;
        end
      end
      S_MUL: begin
        busy        = 1'b1;
        mm_start    = 1'b1;
        w_state_nxt = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        busy = 1'b1;
        if (mm_done) begin
          w_acc_we    = 1'b1;
          w_state_nxt = S_SQR;
        end
      end
      S_SQR: begin
        busy = 1'b1;
        if (w_last_bit) begin
          w_shift     = 1'b1;
          w_state_nxt = S_CHECK;
        end else begin
          mm_start    = 1'b1;
          w_state_nxt = S_SQR_WAIT;
        end
      end
      S_SQR_WAIT: begin
        busy = 1'b1;
        if (mm_done) begin
          w_base_we   = 1'b1;
          w_shift     = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_DONE: begin
        ready       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_base <= '0;
      r_e    <= '0;
      r_n    <= '0;
    end else begin
      if (w_load) begin
        r_acc  <= {{(WIDTH-1){1'b0}}, 1'b1};
        r_base <= msg_i;
        r_e    <= exp_i;
        r_n    <= mod_i;
      end else begin
        if (w_acc_we) begin
          r_acc <= mm_p;
        end
        if (w_base_we) begin
          r_base <= mm_p;
        end
        if (w_shift) begin
          r_e <= r_e >> 1;
        end
      end
    end
  end

  // Operands come straight from acc/base, which only change on the edge that
  // closes a multiply, so they stay stable from launch through mm_done.
  assign mm_a     = (r_state == S_MUL || r_state == S_MUL_WAIT) ? r_acc : r_base;
  assign mm_b     = r_base;
  assign mm_n     = r_n;
  assign result_o = r_acc;

endmodule
`default_nettype wire
